// File: rtl/spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_pkg: op codes, register map and FSM state type for spi_reg_bank. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package spi_reg_pkg;

   localparam logic [1:0] OP_WR = 2'b00;
   localparam logic [1:0] OP_RD = 2'b11;

   localparam logic [7:0] ADDR_BOARD_ID       = 8'h01;
   localparam logic [7:0] ADDR_CONTROL        = 8'h03;
   localparam logic [7:0] ADDR_CPU_MODE       = 8'h05;
   localparam logic [7:0] ADDR_RC_PERIOD      = 8'h09;
   localparam logic [7:0] ADDR_RC_PWIDTH_BASE = 8'h0A;
   localparam logic [7:0] ADDR_SONAR_CTRL     = 8'h1A;
   localparam logic [7:0] ADDR_SONAR_DATA     = 8'h1B;
   localparam logic [7:0] ADDR_VERSION_LO     = 8'h1D;
   localparam logic [7:0] ADDR_VERSION_HI     = 8'h1E;
   localparam logic [7:0] ADDR_STATUS         = 8'h1F;
   localparam logic [7:0] PWM_WIDTH_BASE      = 8'h40;
   localparam logic [7:0] PWM_PERIOD_BASE     = 8'h60;
   localparam logic [7:0] ADDR_LOAD           = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sat_cnt8.sv
// -----------------------------------------------------------------------------
// sat_cnt8: 8-bit up counter that sticks at FF. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sat_cnt8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   output logic [7:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 8'h00;
      end else if (inc && (count != 8'hFF)) begin
         count <= count + 8'h01;
      end
   end

endmodule

`default_nettype wire

// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank: decodes SPI header/data frames into burst register reads/writes. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module spi_reg_bank #(
   parameter int DATA_W          = 16,
   parameter int ADDR_W          = 8,
   parameter int PWM_CH          = 8,
   parameter int RC_CH           = 6,
   parameter int FRAME_LOST_TIME = 2400,
   parameter int PWM_PERIOD_RST  = 20000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rx_data_ready,
   input  logic [DATA_W-1:0]        rx_data,
   output logic                     tx_data_ready,
   output logic [DATA_W-1:0]        tx_data,
   input  logic [3:0]               board_id,
   input  logic [31:0]              version,
   input  logic [DATA_W-1:0]        rc_period,
   input  logic [RC_CH*DATA_W-1:0]  rc_pwidth,
   input  logic [DATA_W-1:0]        sonar_data,
   input  logic                     spi_clk_error,
   output logic [3:0]               cpu_mode,
   output logic [DATA_W-1:0]        control,
   output logic [1:0]               sonar_control,
   output logic [PWM_CH*DATA_W-1:0] pwm_period,
   output logic [PWM_CH*DATA_W-1:0] pwm_width,
   output logic                     pwm_load,
   output logic                     frame_lost_error
);

   import spi_reg_pkg::*;

   localparam int GAP_W = $clog2(FRAME_LOST_TIME + 1);

   state_t                       state;
   state_t                       state_next;
   logic [ADDR_W-1:0]            addr;
   logic [6:0]                   remaining;
   logic [GAP_W-1:0]             gap_cnt;
   logic [1:0]                   hdr_op;
   logic [6:0]                   hdr_len;
   logic [ADDR_W-1:0]            hdr_addr;
   logic                         hdr_wr;
   logic                         hdr_rd;
   logic                         wr_beat;
   logic                         rd_beat;
   logic                         last_beat;
   logic                         timeout_hit;
   logic                         tx_load;
   logic                         load_hit;
   logic [ADDR_W-1:0]            rd_addr;
   logic [DATA_W-1:0]            rd_data;
   logic [PWM_CH*DATA_W-1:0]     shadow_flat;
   logic [RC_CH-1:0][DATA_W-1:0] rc_w;
   logic                         clk_err_q;
   logic [7:0]                   err_clk;
   logic [7:0]                   err_frame;

   assign hdr_op      = rx_data[15:14];
   assign hdr_len     = {1'b0, rx_data[13:8]} + 7'd1;
   assign hdr_addr    = ADDR_W'(rx_data[7:0]);
   assign last_beat   = (remaining == 7'd1);
   // A frame arriving on the terminal count keeps the transaction alive.
   assign timeout_hit = (state != IDLE) && !rx_data_ready
                        && (gap_cnt == GAP_W'(FRAME_LOST_TIME - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (rx_data_ready && (hdr_op == OP_WR)) begin
               state_next = WR;
            end else if (rx_data_ready && (hdr_op == OP_RD)) begin
               state_next = RD;
            end
         end
         WR, RD: begin
            if (timeout_hit || (rx_data_ready && last_beat)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      hdr_wr  = 1'b0;
      hdr_rd  = 1'b0;
      wr_beat = 1'b0;
      rd_beat = 1'b0;
      case (state)
         IDLE: begin
            hdr_wr = rx_data_ready && (hdr_op == OP_WR);
            hdr_rd = rx_data_ready && (hdr_op == OP_RD);
         end
         WR:      wr_beat = rx_data_ready;
         RD:      rd_beat = rx_data_ready;
         default: ;
      endcase
   end

   assign tx_load  = hdr_rd || (rd_beat && !last_beat);
   assign rd_addr  = hdr_rd ? hdr_addr : (addr + ADDR_W'(1));
   assign load_hit = wr_beat && (addr == ADDR_W'(ADDR_LOAD));

   for (genvar n = 0; n < RC_CH; n++) begin : g_rc
      assign rc_w[n] = rc_pwidth[n*DATA_W +: DATA_W];
   end

   for (genvar n = 0; n < PWM_CH; n++) begin : g_pwm
      logic [DATA_W-1:0] shadow_q;
      logic [DATA_W-1:0] width_q;
      logic [DATA_W-1:0] period_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            shadow_q <= '0;
            width_q  <= '0;
            period_q <= DATA_W'(PWM_PERIOD_RST);
         end else begin
            if (wr_beat && (addr == ADDR_W'(int'(PWM_WIDTH_BASE) + n))) begin
               shadow_q <= rx_data;
            end
            if (wr_beat && (addr == ADDR_W'(int'(PWM_PERIOD_BASE) + n))) begin
               period_q <= rx_data;
            end
            if (load_hit) begin
               width_q <= shadow_q;
            end
         end
      end

      assign shadow_flat[n*DATA_W +: DATA_W] = shadow_q;
      assign pwm_width[n*DATA_W +: DATA_W]   = width_q;
      assign pwm_period[n*DATA_W +: DATA_W]  = period_q;
   end

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         ADDR_W'(ADDR_BOARD_ID):   rd_data = DATA_W'(board_id);
         ADDR_W'(ADDR_CONTROL):    rd_data = control;
         ADDR_W'(ADDR_CPU_MODE):   rd_data = DATA_W'(cpu_mode);
         ADDR_W'(ADDR_RC_PERIOD):  rd_data = rc_period;
         ADDR_W'(ADDR_SONAR_CTRL): rd_data = DATA_W'(sonar_control);
         ADDR_W'(ADDR_SONAR_DATA): rd_data = sonar_data;
         ADDR_W'(ADDR_VERSION_LO): rd_data = version[15:0];
         ADDR_W'(ADDR_VERSION_HI): rd_data = version[31:16];
         ADDR_W'(ADDR_STATUS):     rd_data = {err_frame, err_clk};
         default:                  rd_data = '0;
      endcase
      for (int n = 0; n < RC_CH; n++) begin
         if (rd_addr == ADDR_W'(int'(ADDR_RC_PWIDTH_BASE) + n)) begin
            rd_data = rc_w[n];
         end
      end
      for (int n = 0; n < PWM_CH; n++) begin
         if (rd_addr == ADDR_W'(int'(PWM_WIDTH_BASE) + n)) begin
            rd_data = shadow_flat[n*DATA_W +: DATA_W];
         end
         if (rd_addr == ADDR_W'(int'(PWM_PERIOD_BASE) + n)) begin
            rd_data = pwm_period[n*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr             <= '0;
         remaining        <= '0;
         gap_cnt          <= '0;
         tx_data          <= '0;
         tx_data_ready    <= 1'b0;
         control          <= '0;
         cpu_mode         <= '0;
         sonar_control    <= '0;
         pwm_load         <= 1'b0;
         frame_lost_error <= 1'b0;
         clk_err_q        <= 1'b0;
      end else begin
         clk_err_q        <= spi_clk_error;
         pwm_load         <= load_hit;
         frame_lost_error <= timeout_hit;
         tx_data_ready    <= tx_load;

         if (tx_load) begin
            tx_data <= rd_data;
         end else if (state_next == IDLE) begin
            tx_data <= '0;
         end

         if (hdr_wr || hdr_rd) begin
            addr      <= hdr_addr;
            remaining <= hdr_len;
            gap_cnt   <= '0;
         end else if (wr_beat || rd_beat) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - 7'd1;
            gap_cnt   <= '0;
         end else if (state != IDLE) begin
            gap_cnt   <= gap_cnt + GAP_W'(1);
         end

         if (wr_beat) begin
            case (addr)
               ADDR_W'(ADDR_CONTROL):    control       <= rx_data;
               ADDR_W'(ADDR_CPU_MODE):   cpu_mode      <= rx_data[3:0];
               ADDR_W'(ADDR_SONAR_CTRL): sonar_control <= rx_data[1:0];
               default: ;
            endcase
         end
      end
   end

   sat_cnt8 u_err_clk (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (spi_clk_error && !clk_err_q),
      .count (err_clk)
   );

   sat_cnt8 u_err_frame (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (frame_lost_error),
      .count (err_frame)
   );

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bank: directed self-checking bench for spi_reg_bank. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_spi_reg_bank;

   localparam int DATA_W = 16;
   localparam int PWM_CH = 8;
   localparam int RC_CH  = 6;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     rx_data_ready = 1'b0;
   logic [DATA_W-1:0]        rx_data = '0;
   logic                     tx_data_ready;
   logic [DATA_W-1:0]        tx_data;
   logic [3:0]               board_id = 4'hB;
   logic [31:0]              version = 32'hDEAD_BEEF;
   logic [DATA_W-1:0]        rc_period = 16'h4E20;
   logic [RC_CH*DATA_W-1:0]  rc_pwidth;
   logic [DATA_W-1:0]        sonar_data = 16'h0321;
   logic                     spi_clk_error = 1'b0;
   logic [3:0]               cpu_mode;
   logic [DATA_W-1:0]        control;
   logic [1:0]               sonar_control;
   logic [PWM_CH*DATA_W-1:0] pwm_period;
   logic [PWM_CH*DATA_W-1:0] pwm_width;
   logic                     pwm_load;
   logic                     frame_lost_error;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   spi_reg_bank dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .rx_data_ready    (rx_data_ready),
      .rx_data          (rx_data),
      .tx_data_ready    (tx_data_ready),
      .tx_data          (tx_data),
      .board_id         (board_id),
      .version          (version),
      .rc_period        (rc_period),
      .rc_pwidth        (rc_pwidth),
      .sonar_data       (sonar_data),
      .spi_clk_error    (spi_clk_error),
      .cpu_mode         (cpu_mode),
      .control          (control),
      .sonar_control    (sonar_control),
      .pwm_period       (pwm_period),
      .pwm_width        (pwm_width),
      .pwm_load         (pwm_load),
      .frame_lost_error (frame_lost_error)
   );

   // Strobes one frame; returns on the negedge after the capturing posedge.
   task automatic send_frame(input logic [15:0] d);
      @(negedge clk);
      rx_data       = d;
      rx_data_ready = 1'b1;
      @(negedge clk);
      rx_data_ready = 1'b0;
   endtask

   task automatic do_read1(input logic [7:0] a, output logic [15:0] d, output logic r);
      send_frame({8'hC0, a});
      d = tx_data;
      r = tx_data_ready;
      send_frame(16'h0000);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (tx_data !== 16'h0 || tx_data_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_tx: got data=%h rdy=%b want 0000/0", tx_data, tx_data_ready);
      end
      checks++;
      if (control !== 16'h0 || cpu_mode !== 4'h0 || sonar_control !== 2'h0) begin
         errors++;
         $display("FAIL reset_regs: got ctl=%h mode=%h sonar=%h want 0", control, cpu_mode, sonar_control);
      end
      checks++;
      if (pwm_load !== 1'b0 || frame_lost_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses: got load=%b fle=%b want 0/0", pwm_load, frame_lost_error);
      end
      for (int n = 0; n < PWM_CH; n++) begin
         checks++;
         if (pwm_period[n*16 +: 16] !== 16'd20000 || pwm_width[n*16 +: 16] !== 16'd0) begin
            errors++;
            $display("FAIL reset_pwm ch%0d: got per=%0d wid=%0d want 20000/0", n,
                     pwm_period[n*16 +: 16], pwm_width[n*16 +: 16]);
         end
      end
   endtask

   task automatic test_single_write();
      send_frame(16'h0003);
      checks++;
      if (tx_data_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_wr_no_tx: got rdy=%b want 0", tx_data_ready);
      end
      send_frame(16'hA5A5);
      checks++;
      if (control !== 16'hA5A5 || tx_data_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_wr_control: got %h rdy=%b want a5a5 rdy=0", control, tx_data_ready);
      end
   endtask

   task automatic test_burst_write();
      logic [15:0] exp_w [4];
      exp_w = '{16'd100, 16'd200, 16'd300, 16'd400};
      send_frame(16'h0340);
      for (int i = 0; i < 4; i++) send_frame(exp_w[i]);
      checks++;
      if (pwm_width[63:0] !== 64'h0 || pwm_load !== 1'b0) begin
         errors++;
         $display("FAIL burst_wr_width_held: got %h load=%b want 0", pwm_width[63:0], pwm_load);
      end
      send_frame(16'h00FF);
      send_frame(16'h1234);
      checks++;
      if (pwm_load !== 1'b1) begin
         errors++;
         $display("FAIL burst_wr_load_pulse: got %b want 1", pwm_load);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pwm_width[i*16 +: 16] !== exp_w[i]) begin
            errors++;
            $display("FAIL burst_wr_width ch%0d: got %0d want %0d", i, pwm_width[i*16 +: 16], exp_w[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (pwm_load !== 1'b0 || pwm_width[79:64] !== 16'h0) begin
         errors++;
         $display("FAIL burst_wr_load_single: got load=%b w4=%h want 0/0000", pwm_load, pwm_width[79:64]);
      end
      send_frame(16'hC140);
      checks++;
      if (tx_data !== 16'd100) begin
         errors++;
         $display("FAIL shadow_rd0: got %0d want 100", tx_data);
      end
      send_frame(16'h0000);
      checks++;
      if (tx_data !== 16'd200 || tx_data_ready !== 1'b1) begin
         errors++;
         $display("FAIL shadow_rd1: got %0d rdy=%b want 200 rdy=1", tx_data, tx_data_ready);
      end
      send_frame(16'h0000);
   endtask

   task automatic test_burst_read();
      logic [15:0] d;
      logic        r;
      logic [7:0]  addrs [5];
      logic [15:0] exps  [5];
      addrs = '{8'h01, 8'h0C, 8'h02, 8'hFF, 8'h09};
      exps  = '{16'h000B, 16'h1002, 16'h0000, 16'h0000, 16'h4E20};
      send_frame(16'hC11D);
      checks++;
      if (tx_data_ready !== 1'b1 || tx_data !== 16'hBEEF) begin
         errors++;
         $display("FAIL burst_rd_first: got %h rdy=%b want beef rdy=1", tx_data, tx_data_ready);
      end
      @(negedge clk);
      checks++;
      if (tx_data_ready !== 1'b0 || tx_data !== 16'hBEEF) begin
         errors++;
         $display("FAIL burst_rd_hold: got %h rdy=%b want beef rdy=0", tx_data, tx_data_ready);
      end
      send_frame(16'h0000);
      checks++;
      if (tx_data_ready !== 1'b1 || tx_data !== 16'hDEAD) begin
         errors++;
         $display("FAIL burst_rd_second: got %h rdy=%b want dead rdy=1", tx_data, tx_data_ready);
      end
      send_frame(16'h0000);
      checks++;
      if (tx_data_ready !== 1'b0 || tx_data !== 16'h0000) begin
         errors++;
         $display("FAIL burst_rd_end: got %h rdy=%b want 0000 rdy=0", tx_data, tx_data_ready);
      end
      for (int i = 0; i < 5; i++) begin
         do_read1(addrs[i], d, r);
         checks++;
         if (d !== exps[i] || r !== 1'b1) begin
            errors++;
            $display("FAIL read_map %h: got %h rdy=%b want %h rdy=1", addrs[i], d, r, exps[i]);
         end
      end
   endtask

   task automatic test_timeout();
      int          cnt;
      logic [15:0] d;
      logic        r;
      send_frame(16'h0061);
      cnt = 0;
      while (frame_lost_error !== 1'b1 && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      checks++;
      if (cnt != 2400) begin
         errors++;
         $display("FAIL timeout_latency: got %0d cycles want 2400", cnt);
      end
      @(negedge clk);
      checks++;
      if (frame_lost_error !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse_width: got %b want 0", frame_lost_error);
      end
      do_read1(8'h1F, d, r);
      checks++;
      if (d !== 16'h0100) begin
         errors++;
         $display("FAIL timeout_status: got %h want 0100", d);
      end
      send_frame(16'h0003);
      send_frame(16'h0777);
      checks++;
      if (control !== 16'h0777 || pwm_period[31:16] !== 16'd20000) begin
         errors++;
         $display("FAIL timeout_then_header: got ctl=%h per1=%0d want 0777/20000", control, pwm_period[31:16]);
      end
   endtask

   task automatic test_frame_wins();
      int seen;
      seen = 0;
      send_frame(16'h0102);
      for (int i = 0; i < 2398; i++) begin
         @(negedge clk);
         if (frame_lost_error === 1'b1) seen++;
      end
      send_frame(16'h0000);
      if (frame_lost_error === 1'b1) seen++;
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL frame_wins_no_timeout: got %0d pulses want 0", seen);
      end
      send_frame(16'h5A5A);
      checks++;
      if (control !== 16'h5A5A || frame_lost_error !== 1'b0) begin
         errors++;
         $display("FAIL frame_wins_continue: got ctl=%h fle=%b want 5a5a/0", control, frame_lost_error);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [15:0] d;
      logic        r;
      send_frame(16'h0360);
      send_frame(16'd111);
      send_frame(16'd222);
      checks++;
      if (pwm_period[15:0] !== 16'd111 || pwm_period[31:16] !== 16'd222) begin
         errors++;
         $display("FAIL mid_burst_writes: got %0d %0d want 111 222", pwm_period[15:0], pwm_period[31:16]);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (pwm_period[15:0] !== 16'd20000 || pwm_period[31:16] !== 16'd20000 || control !== 16'h0) begin
         errors++;
         $display("FAIL async_reset: got per0=%0d per1=%0d ctl=%h want 20000 20000 0000",
                  pwm_period[15:0], pwm_period[31:16], control);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(16'h0005);
      send_frame(16'h000A);
      checks++;
      if (cpu_mode !== 4'hA || pwm_period[47:32] !== 16'd20000) begin
         errors++;
         $display("FAIL reset_idle: got mode=%h per2=%0d want a/20000", cpu_mode, pwm_period[47:32]);
      end
      send_frame(16'h011A);
      send_frame(16'h0003);
      send_frame(16'h7777);
      do_read1(8'h1B, d, r);
      checks++;
      if (sonar_control !== 2'h3 || d !== 16'h0321) begin
         errors++;
         $display("FAIL sonar: got ctl=%h data=%h want 3/0321", sonar_control, d);
      end
   endtask

   task automatic test_saturation();
      logic [15:0] d;
      logic        r;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk) spi_clk_error = 1'b1;
         @(negedge clk) spi_clk_error = 1'b0;
      end
      repeat (2) @(negedge clk);
      do_read1(8'h1F, d, r);
      checks++;
      if (d !== 16'h000A) begin
         errors++;
         $display("FAIL err_clk_count: got %h want 000a", d);
      end
      for (int i = 0; i < 290; i++) begin
         @(negedge clk) spi_clk_error = 1'b1;
         @(negedge clk) spi_clk_error = 1'b0;
      end
      repeat (2) @(negedge clk);
      do_read1(8'h1F, d, r);
      checks++;
      if (d !== 16'h00FF) begin
         errors++;
         $display("FAIL err_clk_saturate: got %h want 00ff", d);
      end
   endtask

   initial begin
      for (int n = 0; n < RC_CH; n++) rc_pwidth[n*16 +: 16] = 16'h1000 + 16'(n);
      test_reset();
      test_single_write();
      test_burst_write();
      test_burst_read();
      test_timeout();
      test_frame_wins();
      test_reset_mid_burst();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
